// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a debug loader.
// Grant is combinational; the streak counter bounds debug starvation, and a locked debug burst keeps the core out.
module dmem_arbiter #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] conflict_count,
  output logic [31:0] stall_count
);

  typedef enum logic [0:0] {
    S_CORE     = 1'b0,
    S_DBG_LOCK = 1'b1
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       grant_core;
  logic       grant_dbg;

  // Grant decision; reset forces no grant so the memory port and handshakes are quiet
  always_comb begin
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    if (reset) begin
      grant_core = 1'b0;
      grant_dbg  = 1'b0;
    end else begin
      case (state)
        S_CORE: begin
          if (dbg_req && (!core_req || (streak >= STREAK_MAX))) begin
            grant_dbg = 1'b1;
          end else if (core_req) begin
            grant_core = 1'b1;
          end else begin
            grant_core = 1'b0;
          end
        end
        S_DBG_LOCK: begin
          grant_dbg = dbg_req;
        end
        default: begin
          grant_core = 1'b0;
          grant_dbg  = 1'b0;
        end
      endcase
    end
  end

  // Memory port mux: only the granted requester ever reaches memory
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    if (grant_core) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (grant_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else begin
      mem_we    = 1'b0;
    end
  end

  assign core_rdata = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  assign dbg_ack    = grant_dbg;
  assign core_stall = !reset && core_req && !grant_core;

  // FSM, starvation streak and performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_CORE;
      streak         <= 4'd0;
      conflict_count <= 32'h0000_0000;
      stall_count    <= 32'h0000_0000;
    end else begin
      case (state)
        S_CORE: begin
          if (grant_dbg && dbg_lock) begin
            state <= S_DBG_LOCK;
          end else begin
            state <= S_CORE;
          end
        end
        S_DBG_LOCK: begin
          if (!dbg_lock) begin
            state <= S_CORE;
          end else begin
            state <= S_DBG_LOCK;
          end
        end
        default: state <= S_CORE;
      endcase

      if (grant_dbg || !dbg_req) begin
        streak <= 4'd0;
      end else if (grant_core && (streak < STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end else begin
        streak <= streak;
      end

      if (core_req && dbg_req) begin
        conflict_count <= conflict_count + 32'd1;
      end else begin
        conflict_count <= conflict_count;
      end

      if (core_stall) begin
        stall_count <= stall_count + 32'd1;
      end else begin
        stall_count <= stall_count;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model.
module tb_dmem_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, dbg_ack, mem_we;
  logic [31:0] conflict_count, stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit          m_lock;
  int          m_streak;
  logic [31:0] m_conf, m_stall;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];

  dmem_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_count(conflict_count), .stall_count(stall_count)
  );

  // 0 = nobody, 1 = core, 2 = debug
  function automatic logic [1:0] model_grant();
    if (reset) return 2'd0;
    if (m_lock) return dbg_req ? 2'd2 : 2'd0;
    if (dbg_req && (!core_req || m_streak == MAX_STREAK)) return 2'd2;
    if (core_req) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_streak = 0; m_conf = 32'h0; m_stall = 32'h0;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic dlock, input logic [31:0] daddr, input logic [31:0] dwd);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_lock = dlock; dbg_addr = daddr; dbg_wdata = dwd;
  endtask

  // advance one clock edge and update the model from the inputs seen at that edge
  task automatic tick();
    logic [1:0] g;
    @(posedge clk);
    g = model_grant();
    if (!reset) begin
      if (core_req && dbg_req) m_conf = m_conf + 32'd1;
      if (core_req && g != 2'd1) m_stall = m_stall + 32'd1;
      if (g == 2'd2 || !dbg_req) m_streak = 0;
      else if (g == 2'd1 && m_streak < MAX_STREAK) m_streak = m_streak + 1;
      if (!m_lock) m_lock = (g == 2'd2) && dbg_lock;
      else m_lock = dbg_lock;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'd40, 32'd7, 1'b1, 1'b1, 1'b1, 32'd44, 32'd9);
    #2;
    n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", core_stall); end
    n_checks++; if (dbg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %0b want 0", dbg_ack); end
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_memport got we=%0b addr=%h wdata=%h want 0/0/0", mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    n_checks++; if (conflict_count !== 32'h0 || stall_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", conflict_count, stall_count); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_core_only();
    drive(1'b1, 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd100 || mem_wdata !== 32'd25) begin
      n_fail++; $display("FAIL core_only_port got we=%0b addr=%0d wdata=%0d want 1/100/25", mem_we, mem_addr, mem_wdata); end
    n_checks++; if (core_stall !== 1'b0 || dbg_ack !== 1'b0) begin
      n_fail++; $display("FAIL core_only_hs got stall=%0b ack=%0b want 0/0", core_stall, dbg_ack); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0, 32'd12, 32'd0);
      @(negedge clk);
      n_checks++; if (dbg_ack !== (i % 5 == 0) || core_stall !== (i % 5 == 0)) begin
        n_fail++; $display("FAIL contention_cycle%0d got ack=%0b stall=%0b want %0b", i, dbg_ack, core_stall, (i % 5 == 0)); end
      tick();
    end
    n_checks++; if (conflict_count !== 32'd10) begin n_fail++; $display("FAIL contention_conflicts got %0d want 10", conflict_count); end
    n_checks++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL contention_stalls got %0d want 2", stall_count); end
  endtask

  task automatic test_idle_core_read();
    drive(1'b1, 1'b1, 32'd96, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd96, 32'd0);
    @(negedge clk);
    n_checks++; if (dbg_ack !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_read_ack got ack=%0b we=%0b want 1/0", dbg_ack, mem_we); end
    n_checks++; if (dbg_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_read_data got %h want deadbeef", dbg_rdata); end
    tick();
    n_checks++; if (dut.streak !== 4'd0) begin n_fail++; $display("FAIL idle_read_streak got %0d want 0", dut.streak); end
  endtask

  task automatic test_burst_lock();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 1'b0, 32'd20, 32'd0, 1'b1, 1'b1, (i != 7), 32'd60 + 32'(i), 32'(i));
      @(negedge clk);
      n_checks++; if (dbg_ack !== (i >= 5) || core_stall !== (i >= 5)) begin
        n_fail++; $display("FAIL burst_cycle%0d got ack=%0b stall=%0b want %0b", i, dbg_ack, core_stall, (i >= 5)); end
      tick();
    end
    n_checks++; if (stall_count !== 32'd3) begin n_fail++; $display("FAIL burst_stalls got %0d want 3", stall_count); end
    drive(1'b1, 1'b0, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b0 || mem_addr !== 32'd20) begin
      n_fail++; $display("FAIL burst_release got stall=%0b addr=%0d want 0/20", core_stall, mem_addr); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd70, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd30, 32'd0, 1'b1, 1'b0, 1'b1, 32'd71, 32'd0);
      tick();
    end
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b1 || stall_count !== 32'd2) begin
      n_fail++; $display("FAIL midburst_locked got stall=%0b count=%0d want 1/2", core_stall, stall_count); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (core_stall !== 1'b0 || dbg_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL midburst_reset_hs got stall=%0b ack=%0b we=%0b want 0/0/0", core_stall, dbg_ack, mem_we); end
    n_checks++; if (conflict_count !== 32'h0 || stall_count !== 32'h0) begin
      n_fail++; $display("FAIL midburst_reset_cnt got %0d/%0d want 0/0", conflict_count, stall_count); end
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (core_stall !== 1'b0 || dbg_ack !== 1'b0 || mem_addr !== 32'd30) begin
      n_fail++; $display("FAIL midburst_after got stall=%0b ack=%0b addr=%0d want 0/0/30", core_stall, dbg_ack, mem_addr); end
    tick();
  endtask

  task automatic test_counter_wrap();
    force dut.conflict_count = 32'hFFFF_FFFF;
    #1 release dut.conflict_count;
    m_conf = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    n_checks++; if (conflict_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffffffff", conflict_count); end
    tick();
    n_checks++; if (conflict_count !== 32'h0) begin n_fail++; $display("FAIL wrap_result got %h want 0", conflict_count); end
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
            $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
            32'($urandom_range(0, 255)), $urandom);
      @(negedge clk);
      g       = model_grant();
      e_we    = (g == 2'd1) ? core_we    : (g == 2'd2) ? dbg_we    : 1'b0;
      e_addr  = (g == 2'd1) ? core_addr  : (g == 2'd2) ? dbg_addr  : 32'h0;
      e_wdata = (g == 2'd1) ? core_wdata : (g == 2'd2) ? dbg_wdata : 32'h0;
      n_checks++; if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        n_fail++; $display("FAIL rand%0d_port got %0b/%h/%h want %0b/%h/%h", i, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata); end
      n_checks++; if (dbg_ack !== (g == 2'd2) || core_stall !== (core_req && g != 2'd1)) begin
        n_fail++; $display("FAIL rand%0d_hs got ack=%0b stall=%0b want %0b/%0b", i, dbg_ack, core_stall, (g == 2'd2), (core_req && g != 2'd1)); end
      if (g == 2'd1) begin
        n_checks++; if (core_rdata !== mem[e_addr[7:0]]) begin
          n_fail++; $display("FAIL rand%0d_core_rdata got %h want %h", i, core_rdata, mem[e_addr[7:0]]); end
      end else if (g == 2'd2) begin
        n_checks++; if (dbg_rdata !== mem[e_addr[7:0]]) begin
          n_fail++; $display("FAIL rand%0d_dbg_rdata got %h want %h", i, dbg_rdata, mem[e_addr[7:0]]); end
      end
      n_checks++; if (conflict_count !== m_conf || stall_count !== m_stall) begin
        n_fail++; $display("FAIL rand%0d_counters got %0d/%0d want %0d/%0d", i, conflict_count, stall_count, m_conf, m_stall); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_core_only();
    test_contention();
    test_idle_core_read();
    test_burst_lock();
    test_reset_mid_burst();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
